alu_share_ctrl: RTL

//  Sequences one shared 32-bit ALU between two requesters (e.g. main datapath and an

---
 rtl/alu_share_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external ALU between two requesters.
// Round-robin arbitration, one operation in flight. Each request goes
// IDLE -> EXEC -> RESP, and the registered result is held until the owner accepts it.
`timescale 1ns/1ps
module alu_share_ctrl #(
  parameter int                WIDTH   = 32,
  parameter int                OPW     = 4,
  parameter logic [OPW-1:0]    IDLE_OP = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_aluc,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_aluc,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_s,
  output logic             rsp0_z,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_s,
  output logic             rsp1_z,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_aluc,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_z
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q;
  logic               last_grant_q;  // requester served most recently
  logic               owner_q;       // requester owning the op in flight
  logic [OPW-1:0]     op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               rsp0_valid_q;
  logic               rsp1_valid_q;
  logic [WIDTH-1:0]   rsp0_s_q;
  logic [WIDTH-1:0]   rsp1_s_q;
  logic               rsp0_z_q;
  logic               rsp1_z_q;
  logic               grant0_d;
  logic               grant1_d;

  // Grant decision: only in IDLE, at most one requester; a tie goes to
  // the requester that was not served last.
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0_d = 1'b1;
      end else if (req1_valid) begin
        grant1_d = 1'b1;
      end
    end
  end

  assign req0_ready = grant0_d;
  assign req1_ready = grant1_d;

  // The ALU sees the latched operands only during EXEC; otherwise it sees an idle op.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_aluc = IDLE_OP;
    if (state_q == EXEC) begin
      alu_a    = a_q;
      alu_b    = b_q;
      alu_aluc = op_q;
    end
  end

  // Sequencer: latch on accept, capture the ALU result after EXEC, hold it until the owner takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_s_q     <= '0;
      rsp1_s_q     <= '0;
      rsp0_z_q     <= 1'b0;
      rsp1_z_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0_d || grant1_d) begin
            op_q         <= grant1_d ? req1_aluc : req0_aluc;
            a_q          <= grant1_d ? req1_a    : req0_a;
            b_q          <= grant1_d ? req1_b    : req0_b;
            owner_q      <= grant1_d;
            last_grant_q <= grant1_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (owner_q) begin
            rsp1_s_q     <= alu_s;
            rsp1_z_q     <= alu_z;
            rsp1_valid_q <= 1'b1;
          end else begin
            rsp0_s_q     <= alu_s;
            rsp0_z_q     <= alu_z;
            rsp0_valid_q <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (owner_q && rsp1_ready) begin
            rsp1_valid_q <= 1'b0;
            state_q      <= IDLE;
          end else if (!owner_q && rsp0_ready) begin
            rsp0_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_s     = rsp0_s_q;
  assign rsp1_s     = rsp1_s_q;
  assign rsp0_z     = rsp0_z_q;
  assign rsp1_z     = rsp1_z_q;

endmodule
